// File: rtl/key_input_pkg.sv
// Shared constants for the key input array: default timing at a 1 MHz clock,
// board key indices, and small helpers for sizing counters.
package key_input_pkg;

    localparam int NUM_KEYS_DEF = 3;

    // Default timing, in clock cycles at 1 MHz
    localparam int STABLE = 10000;   // 10 ms debounce window
    localparam int DELAY  = 400000;  // 400 ms before the first auto-repeat
    localparam int PERIOD = 150000;  // 150 ms between auto-repeats

    // Board key positions within the i_in vector
    localparam int KEY_RIGHT = 0;
    localparam int KEY_PLAY  = 1;
    localparam int KEY_LEFT  = 2;

    // Bits needed for a counter whose values stay strictly below 'limit'
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_input_chan.sv
// One key channel: 2-flop synchronizer, debounce, press/release edge pulses,
// and auto-repeat while the key is held with repeat enabled.
module key_input_chan
    import key_input_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE,
    parameter int REPEAT_DELAY  = DELAY,
    parameter int REPEAT_PERIOD = PERIOD,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_neg,
    output logic o_pos,
    output logic o_rep
);

    localparam int STAB_W = cnt_width(STABLE_CYCLES);
    localparam int REP_W  = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [STAB_W-1:0] STABLE_LAST  = STAB_W'(STABLE_CYCLES - 1);
    // The counter restarts one cycle after the press pulse, so the first
    // repeat fires when it reaches DELAY-2 (the pulse lands on the next cycle).
    localparam logic [REP_W-1:0]  FIRST_MATCH  = REP_W'((REPEAT_DELAY >= 2) ? REPEAT_DELAY - 2 : 0);
    localparam logic [REP_W-1:0]  PERIOD_MATCH = REP_W'(REPEAT_PERIOD - 1);
    localparam logic              RELEASED_RAW = (ACTIVE_LOW != 0);
    localparam logic              DELAY_IS_ONE = (REPEAT_DELAY == 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [STAB_W-1:0] r_stab_cnt;
    logic              r_level;
    logic              r_neg;
    logic              r_pos;
    logic              r_rep;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_rep_running;   // 0 = waiting for first repeat, 1 = periodic

    logic w_pressed;
    logic w_differs;
    logic w_toggle;
    logic w_rep_hit;
    logic w_rep_fire;
    logic w_rep_clear;

    // Normalise to 1 = pressed and decide whether the debounced level flips
    always_comb begin
        w_pressed = r_sync2 ^ RELEASED_RAW;
        w_differs = (w_pressed != r_level);
        w_toggle  = w_differs && (r_stab_cnt == STABLE_LAST);
    end

    // Repeat decision; a repeat is never issued on the cycle the level drops
    always_comb begin
        if (r_rep_running) begin
            w_rep_hit = (r_rep_cnt == PERIOD_MATCH);
        end else if (DELAY_IS_ONE) begin
            w_rep_hit = 1'b1;
        end else begin
            w_rep_hit = !r_neg && (r_rep_cnt == FIRST_MATCH);
        end
        w_rep_clear = r_neg || !r_level || !i_repeat_en;
        w_rep_fire  = r_level && i_repeat_en && !w_toggle && w_rep_hit;
    end

    // Two-flop synchronizer; reset parks it at the released raw level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= RELEASED_RAW;
            r_sync2 <= RELEASED_RAW;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, debounced level and registered edge pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stab_cnt <= '0;
            r_level    <= 1'b0;
            r_neg      <= 1'b0;
            r_pos      <= 1'b0;
        end else begin
            if (!w_differs || w_toggle) begin
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end
            if (w_toggle) begin
                r_level <= !r_level;
            end
            r_neg <= w_toggle && !r_level;
            r_pos <= w_toggle && r_level;
        end
    end

    // Auto-repeat counter and pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep_cnt     <= '0;
            r_rep_running <= 1'b0;
            r_rep         <= 1'b0;
        end else begin
            r_rep <= w_rep_fire;
            if (w_rep_fire) begin
                r_rep_cnt     <= '0;
                r_rep_running <= 1'b1;
            end else if (w_rep_clear) begin
                r_rep_cnt     <= '0;
                r_rep_running <= 1'b0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_neg   = r_neg;
    assign o_pos   = r_pos;
    assign o_rep   = r_rep;

endmodule

// File: rtl/key_input_array.sv
// Array of independent debounced key channels with a combined activity flag
// that fires on any press or auto-repeat.
module key_input_array
    import key_input_pkg::*;
#(
    parameter int NUM_KEYS      = NUM_KEYS_DEF,
    parameter int STABLE_CYCLES = STABLE,
    parameter int REPEAT_DELAY  = DELAY,
    parameter int REPEAT_PERIOD = PERIOD,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_in,
    input  logic [NUM_KEYS-1:0] i_repeat_en,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_neg,
    output logic [NUM_KEYS-1:0] o_pos,
    output logic [NUM_KEYS-1:0] o_rep,
    output logic                o_any
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_input_chan #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_chan (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_in        (i_in[gi]),
                .i_repeat_en (i_repeat_en[gi]),
                .o_level     (o_level[gi]),
                .o_neg       (o_neg[gi]),
                .o_pos       (o_pos[gi]),
                .o_rep       (o_rep[gi])
            );
        end
    endgenerate

    // Pulses are registered inside each channel, so this OR is glitch-safe
    assign o_any = |(o_neg | o_rep);

endmodule

// File: tb/tb_key_input_array.sv
// Bench for key_input_array: directed scenarios plus a randomized run, all
// checked against a window-based behavioural model kept in this file.
module tb_key_input_array;

    localparam int NK   = 3;
    localparam int SC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int AL   = 1;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] in_raw = '1;
    logic [NK-1:0] rep_en = '0;
    logic [NK-1:0] o_level, o_neg, o_pos, o_rep;
    logic          o_any;

    key_input_array #(
        .NUM_KEYS      (NK),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .ACTIVE_LOW    (AL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in        (in_raw),
        .i_repeat_en (rep_en),
        .o_level     (o_level),
        .o_neg       (o_neg),
        .o_pos       (o_pos),
        .o_rep       (o_rep),
        .o_any       (o_any)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: per-cycle history of inputs and the derived key levels
    int            cyc      = 0;
    int            last_rst = 0;
    logic [NK-1:0] raw_h [MAXC];
    logic [NK-1:0] en_h  [MAXC];
    logic [NK-1:0] syn_h [MAXC];
    logic [NK-1:0] lvl_h [MAXC];
    logic [NK-1:0] neg_h [MAXC];
    logic          rst_h [MAXC];
    int            anchor [NK];
    bit            armed  [NK];
    logic [NK-1:0] m_level, m_neg, m_pos, m_rep;
    logic          m_any;

    // Compute expected outputs for cycle 'cyc' from the recorded history.
    // A key flips once its synchronized value has disagreed with the current
    // level for SC whole cycles since the last reset; repeats fall at
    // anchor+RD+n*RP where the anchor is the press or the last disabled cycle.
    task automatic model_step();
        int t;
        bit stable;
        t = cyc;
        for (int ch = 0; ch < NK; ch++) begin
            if (lvl_h[t-1][ch] === 1'b1) begin
                if (neg_h[t-1][ch] === 1'b1 || en_h[t-1][ch] !== 1'b1) begin
                    anchor[ch] = t - 1;
                    armed[ch]  = 1'b1;
                end
            end else begin
                armed[ch] = 1'b0;
            end
        end
        m_pos = '0;
        m_rep = '0;
        if (rst_h[t-1] === 1'b1) begin
            last_rst = t - 1;
            syn_h[t] = '0;
            lvl_h[t] = '0;
            neg_h[t] = '0;
            for (int ch = 0; ch < NK; ch++) armed[ch] = 1'b0;
        end else begin
            if (t >= 2 && rst_h[t-2] !== 1'b1)
                syn_h[t] = (AL != 0) ? ~raw_h[t-2] : raw_h[t-2];
            else
                syn_h[t] = '0;
            for (int ch = 0; ch < NK; ch++) begin
                stable = (t - SC > last_rst);
                if (stable) begin
                    for (int k = 1; k <= SC; k++)
                        if (syn_h[t-k][ch] === lvl_h[t-1][ch]) stable = 1'b0;
                end
                lvl_h[t][ch] = stable ? ~lvl_h[t-1][ch] : lvl_h[t-1][ch];
                m_pos[ch] = lvl_h[t-1][ch] & ~lvl_h[t][ch];
                m_rep[ch] = armed[ch] && lvl_h[t][ch] && (t - anchor[ch] >= RD)
                            && (((t - anchor[ch] - RD) % RP) == 0);
            end
            neg_h[t] = lvl_h[t] & ~lvl_h[t-1];
        end
        m_level = lvl_h[t];
        m_neg   = neg_h[t];
        m_any   = |(m_neg | m_rep);
    endtask

    // Record this cycle's inputs, advance one clock, sample 1 ns after the edge
    task automatic tick();
        if (cyc >= MAXC - 2) begin
            $display("FAIL tick_budget: cycle %0d exceeds limit %0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        raw_h[cyc] = in_raw;
        en_h[cyc]  = rep_en;
        rst_h[cyc] = rst;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        in_raw = '1;
        rep_en = '0;
        tick();
        tick();
        tests_run++;
        if ({o_level, o_neg, o_pos, o_rep, o_any} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected all zero", {o_level, o_neg, o_pos, o_rep, o_any});
        end
        rst = 1'b0;
        repeat (8) tick();
        tests_run++;
        if ({o_level, o_neg, o_pos, o_rep, o_any} !== '0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b expected all zero", {o_level, o_neg, o_pos, o_rep, o_any});
        end
    endtask

    task automatic test_clean_press();
        int neg_cnt = 0, neg_at = -1, lvl_at = -1, pos_cnt = 0, pos_at = -1;
        rep_en    = '0;
        in_raw[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_neg[0] === 1'b1) begin neg_cnt++; neg_at = k; end
            if (o_level[0] === 1'b1 && lvl_at < 0) lvl_at = k;
        end
        tests_run++;
        if (neg_cnt != 1 || neg_at != 6) begin
            tests_failed++;
            $display("FAIL clean_neg: got count=%0d at=%0d expected count=1 at=6", neg_cnt, neg_at);
        end
        tests_run++;
        if (lvl_at != 6) begin
            tests_failed++;
            $display("FAIL clean_level: got rise at=%0d expected 6", lvl_at);
        end
        in_raw[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_pos[0] === 1'b1) begin pos_cnt++; pos_at = k; end
        end
        tests_run++;
        if (pos_cnt != 1 || pos_at != 6 || o_level[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_pos: got count=%0d at=%0d level=%b expected count=1 at=6 level=0",
                     pos_cnt, pos_at, o_level[0]);
        end
    endtask

    task automatic test_bounce();
        int neg_cnt = 0, neg_at = -1;
        rep_en    = '0;
        in_raw[1] = 1'b0;
        tick();
        if (o_neg[1] === 1'b1) neg_cnt++;
        in_raw[1] = 1'b1;
        tick();
        if (o_neg[1] === 1'b1) neg_cnt++;
        in_raw[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_neg[1] === 1'b1) begin neg_cnt++; neg_at = k; end
        end
        tests_run++;
        if (neg_cnt != 1 || neg_at != 6) begin
            tests_failed++;
            $display("FAIL bounce_neg: got count=%0d at=%0d expected count=1 at=6", neg_cnt, neg_at);
        end
        in_raw[1] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_repeat();
        int neg_seen = 0, pos_at = -1, late_rep = 0;
        int reps[$];
        rep_en[2] = 1'b1;
        in_raw[2] = 1'b0;
        for (int k = 0; k < 15 && neg_seen == 0; k++) begin
            tick();
            if (o_neg[2] === 1'b1) neg_seen = 1;
        end
        tests_run++;
        if (neg_seen == 0) begin
            tests_failed++;
            $display("FAIL repeat_press_timeout: got no o_neg[2] expected one within 15 cycles");
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (o_rep[2] === 1'b1) begin
                reps.push_back(k);
                if (pos_at >= 0 || o_pos[2] === 1'b1) late_rep++;
            end
            if (o_pos[2] === 1'b1 && pos_at < 0) pos_at = k;
            if (k == 13) in_raw[2] = 1'b1;
        end
        tests_run++;
        if (reps.size() != 3 || reps[0] != 10 || reps[1] != 13 || reps[2] != 16) begin
            tests_failed++;
            $display("FAIL repeat_times: got %p expected '{10, 13, 16}", reps);
        end
        tests_run++;
        if (pos_at != 19 || late_rep != 0) begin
            tests_failed++;
            $display("FAIL repeat_release: got pos_at=%0d late_reps=%0d expected pos_at=19 late_reps=0",
                     pos_at, late_rep);
        end
        rep_en[2] = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_repeat_disabled();
        int neg_cnt = 0, rep_cnt = 0, any_cnt = 0, any_bad = 0;
        rep_en    = '0;
        in_raw[0] = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (o_neg[0] === 1'b1) neg_cnt++;
            if (o_rep !== '0) rep_cnt++;
            if (o_any === 1'b1) begin
                any_cnt++;
                if (o_neg[0] !== 1'b1) any_bad++;
            end
        end
        tests_run++;
        if (neg_cnt != 1 || rep_cnt != 0) begin
            tests_failed++;
            $display("FAIL norepeat_pulses: got neg=%0d rep=%0d expected neg=1 rep=0", neg_cnt, rep_cnt);
        end
        tests_run++;
        if (any_cnt != 1 || any_bad != 0) begin
            tests_failed++;
            $display("FAIL norepeat_any: got any=%0d stray=%0d expected any=1 stray=0", any_cnt, any_bad);
        end
        in_raw[0] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        int hit = 0, pos_hit = 0;
        logic [NK-1:0] neg_val = '0, pos_val = '0;
        logic any_val = 1'b0;
        rep_en = '0;
        in_raw = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_neg !== '0) begin hit++; neg_val = o_neg; any_val = o_any; end
        end
        tests_run++;
        if (hit != 1 || neg_val !== 3'b111 || any_val !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_neg: got cycles=%0d neg=%b any=%b expected cycles=1 neg=111 any=1",
                     hit, neg_val, any_val);
        end
        in_raw = '1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_pos !== '0) begin pos_hit++; pos_val = o_pos; end
        end
        tests_run++;
        if (pos_hit != 1 || pos_val !== 3'b111) begin
            tests_failed++;
            $display("FAIL simul_pos: got cycles=%0d pos=%b expected cycles=1 pos=111", pos_hit, pos_val);
        end
    endtask

    task automatic test_reset_mid_hold();
        int neg_seen = 0, neg_at = -1, stray = 0;
        logic [4*NK:0] after_rst;
        rep_en[0] = 1'b1;
        in_raw[0] = 1'b0;
        for (int k = 0; k < 15 && neg_seen == 0; k++) begin
            tick();
            if (o_neg[0] === 1'b1) neg_seen = 1;
        end
        tests_run++;
        if (neg_seen == 0) begin
            tests_failed++;
            $display("FAIL midrst_press_timeout: got no o_neg[0] expected one within 15 cycles");
        end
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        after_rst = {o_level, o_neg, o_pos, o_rep, o_any};
        tests_run++;
        if (after_rst !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %b expected all zero", after_rst);
        end
        for (int k = 1; k <= 15 && neg_at < 0; k++) begin
            tick();
            if (o_neg[0] === 1'b1) neg_at = k;
            else if ((o_neg | o_pos | o_rep) !== '0) stray++;
        end
        tests_run++;
        if (neg_at != 6 || stray != 0) begin
            tests_failed++;
            $display("FAIL midrst_repress: got neg_at=%0d stray=%0d expected neg_at=6 stray=0", neg_at, stray);
        end
        rep_en[0] = 1'b0;
        in_raw[0] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 500; i++) begin
            for (int ch = 0; ch < NK; ch++)
                if ($urandom_range(0, 19) == 0) in_raw[ch] = ~in_raw[ch];
            if ($urandom_range(0, 39) == 0) rep_en = NK'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            tests_run++;
            if ({o_level, o_neg, o_pos, o_rep, o_any} !== {m_level, m_neg, m_pos, m_rep, m_any}) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d: got lvl=%b neg=%b pos=%b rep=%b any=%b expected lvl=%b neg=%b pos=%b rep=%b any=%b",
                             cyc, o_level, o_neg, o_pos, o_rep, o_any, m_level, m_neg, m_pos, m_rep, m_any);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            raw_h[i] = '1;
            en_h[i]  = '0;
            syn_h[i] = '0;
            lvl_h[i] = '0;
            neg_h[i] = '0;
            rst_h[i] = 1'b0;
        end
        for (int ch = 0; ch < NK; ch++) begin
            anchor[ch] = 0;
            armed[ch]  = 1'b0;
        end
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_repeat_disabled();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
